result_writer: RTL and testbench
================================

# result_writer

Drains the systolic array's C_ROWS×C_COLS accumulator results into the result-matrix Data_Mem instance, one element per clock, in row-major order. It is the write-side counterpart of the A/B operand memories: the array pulses `start` when its accumulators are final, the block snapshots them, narrows each to the memory data width and drives the memory's `wr_en`/`addr`/`data_in`. It sits between the PE grid and the matrix C Data_Mem inside the systolic-array top.

## Interface
- `C_ROWS`, 3, result rows (= A_ROWS)
- `C_COLS`, 3, result columns (= B_COLS)
- `ACC_WIDTH`, 32, signed accumulator width per PE
- `DATA_WIDTH`, 16, signed memory word width; must be ≤ ACC_WIDTH
- `ADDR_WIDTH`, $clog2(C_ROWS*C_COLS), memory address width
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  results valid pulse from array; sampled only in IDLE
- `results`  in  C_ROWS*C_COLS*ACC_WIDTH  flattened accumulators; element k = r*C_COLS+c at `[k*ACC_WIDTH +: ACC_WIDTH]`
- `busy`  out  1  high in WRITE and DONE
- `done`  out  1  one-cycle pulse after last write
- `mem_wr_en`  out  1  to Data_Mem `wr_en`
- `mem_addr`  out  ADDR_WIDTH  to Data_Mem `addr`
- `mem_data`  out  DATA_WIDTH  to Data_Mem `data_in`
- `ovf`  out  1  sticky saturation flag (constant 0 without RESULT_WRITER_SAT_EN)

## Operation
- States: IDLE, WRITE, DONE. N = C_ROWS*C_COLS.
- IDLE: `start`=1 → copy all of `results` into internal snapshot bank, clear counter `cnt`, clear `ovf`, go WRITE. `start`=0 → stay.
- WRITE: registered outputs `mem_wr_en`=1, `mem_addr`=cnt, `mem_data`=narrow(snap[cnt]); `cnt` increments each cycle; after the write with cnt=N-1 → DONE.
- DONE: `mem_wr_en`=0, `done`=1 for exactly one cycle → IDLE.
- `start` in WRITE or DONE is ignored; snapshot is never modified mid-drain, so `results` may change freely after the accepted `start`.
- Narrowing: signed; see Configuration. Address never wraps: cnt spans 0..N-1 only.
- Reset (`reset`=0, any time, including mid-drain): state IDLE, `cnt`=0, `busy`=0, `done`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_data`=0, `ovf`=0; drain is abandoned, no partial resume.

## Timing
- Edge 0: `start` sampled high in IDLE.
- Edges 1..N: write k presented after edge k+1... precisely: after edge 1, outputs show address 0; after edge k+1, address k; Data_Mem captures on the following edge.
- After edge N+1: `mem_wr_en`=0, `done`=1, `busy`=1.
- After edge N+2: IDLE, `busy`=0; a `start` present at edge N+2 is accepted (back-to-back drain, one idle gap cycle minimum before edge N+2 excluded).
- Total: N write cycles, start-to-done latency N+1 cycles.

## Configuration
- `RESULT_WRITER_SAT_EN` defined: narrow() saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; any clamped element sets `ovf` (sticky until next accepted `start` or reset).
- Not defined: narrow() takes the low DATA_WIDTH bits (two's-complement wrap); `ovf` tied 0.

## Test plan
- 3×3, results k = k*100 (0..800), pulse start → 9 writes addr 0..8 data 0,100,..,800 on consecutive cycles, `done` one cycle after addr 8, `busy` high 10 cycles.
- SAT_EN, element 4 = 40000, element 5 = -40000 → data[4]=32767, data[5]=-32768, `ovf`=1 from addr-4 write until next start; without SAT_EN → data[4]=-25536 (0x9C40), data[5]=25536, `ovf`=0.
- Change `results` and pulse `start` while at addr 3 → start ignored, remaining writes use original snapshot, exactly 9 writes total.
- Assert `reset` low at addr 5 → all outputs 0 asynchronously, no further writes; new start after release drains from addr 0.
- Hold `start` high continuously → drains repeat with period N+2 cycles, `done` once per drain, no write during DONE cycle.

Source files
------------

// File: rtl/result_writer.sv
// ----------------------------------------------------------------------------
// result_writer
//   Drains the systolic array's C_ROWS x C_COLS accumulator results into the
//   result-matrix Data_Mem, one element per clock, in row-major order.
//   A `start` pulse in IDLE snapshots every accumulator, so the array may
//   change `results` freely while the drain is in progress.
//
//   Optional feature macro: RESULT_WRITER_SAT_EN
//     defined   : accumulators are saturated to the signed DATA_WIDTH range and
//                 any clamped element sets the sticky `ovf` flag
//     undefined : accumulators are wrapped (low DATA_WIDTH bits), `ovf` is 0
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   start      in   results-valid pulse from the array (sampled in IDLE only)
//   results    in   flattened accumulators, element k = r*C_COLS+c
//   busy       out  high while writing and during the done cycle
//   done       out  one-cycle pulse after the last write
//   mem_wr_en  out  Data_Mem write enable
//   mem_addr   out  Data_Mem address
//   mem_data   out  Data_Mem write data
//   ovf        out  sticky saturation flag
// ----------------------------------------------------------------------------
module result_writer #(
    parameter int unsigned C_ROWS     = 3,
    parameter int unsigned C_COLS     = 3,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(C_ROWS * C_COLS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [C_ROWS*C_COLS*ACC_WIDTH-1:0]   results,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 mem_wr_en,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_data,
    output logic                                 ovf
);

    localparam int unsigned N = C_ROWS * C_COLS;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]  snap_q [N];
    logic [ACC_WIDTH-1:0]  snap_d [N];

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  ovf_q, ovf_d;

    // Element currently being drained and its narrowed form.
    logic signed [ACC_WIDTH-1:0] cur_acc;
    logic [DATA_WIDTH-1:0]       cur_data;
    logic                        cur_clamp;

    assign cur_acc = snap_q[cnt_q];

`ifdef RESULT_WRITER_SAT_EN
    // Signed limits of the memory word, sign-extended to accumulator width.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    // Saturating narrow: clamp to the signed memory range and flag it.
    always_comb begin
        cur_clamp = 1'b0;
        cur_data  = cur_acc[DATA_WIDTH-1:0];
        if (cur_acc > SAT_MAX) begin
            cur_clamp = 1'b1;
            cur_data  = SAT_MAX[DATA_WIDTH-1:0];
        end else if (cur_acc < SAT_MIN) begin
            cur_clamp = 1'b1;
            cur_data  = SAT_MIN[DATA_WIDTH-1:0];
        end
    end
`else
    // Wrapping narrow: keep the low bits; the upper accumulator bits are
    // intentionally discarded.
    logic unused_acc;
    assign unused_acc = ^cur_acc;
    assign cur_clamp  = 1'b0;
    assign cur_data   = cur_acc[DATA_WIDTH-1:0];
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        wr_en_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int unsigned k = 0; k < N; k++) begin
                        snap_d[k] = results[k*ACC_WIDTH +: ACC_WIDTH];
                    end
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                busy_d  = 1'b1;
                wr_en_d = 1'b1;
                addr_d  = cnt_q;
                data_d  = cur_data;
                ovf_d   = ovf_q | cur_clamp;
                // Counter stops at the last address; it never wraps.
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any drain in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            for (int unsigned k = 0; k < N; k++) begin
                snap_q[k] <= '0;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int unsigned k = 0; k < N; k++) begin
                snap_q[k] <= snap_d[k];
            end
            busy_q  <= busy_d;
            done_q  <= done_d;
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_wr_en = wr_en_q;
    assign mem_addr  = addr_q;
    assign mem_data  = data_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_result_writer.sv
// Scoreboard bench for result_writer (3x3, 32-bit accumulators, 16-bit words).
module tb_result_writer;

    localparam int N = 9;

`ifdef RESULT_WRITER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [N*32-1:0] results;
    logic            busy;
    logic            done;
    logic            mem_wr_en;
    logic [3:0]      mem_addr;
    logic [15:0]     mem_data;
    logic            ovf;

    result_writer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .results   (results),
        .busy      (busy),
        .done      (done),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        bit ovf;
    } item_t;

    item_t q[$];
    int    done_cyc[$];
    int    errors   = 0;
    int    checks   = 0;
    int    cyc      = 0;
    int    wr_total = 0;
    logic       prev_wr   = 1'b0;
    logic [3:0] prev_addr = 4'd0;

    int pat_a [N];
    int pat_b [N];
    int pat_c [N];
    int pat_d [N];
    int pat_x [N];
    int acc_ov[N];
    int exp_ov[N];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write presented by the DUT is checked against the queue.
    always @(negedge clk) begin
        if (reset) begin
            if (mem_wr_en) begin
                item_t      it;
                logic [15:0] ed;
                wr_total++;
                chk("write_expected", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    it = q.pop_front();
                    ed = it.data[15:0];
                    chk("wr_addr", {28'h0, mem_addr}, 32'(it.addr));
                    chk("wr_data", {16'h0, mem_data}, {16'h0, ed});
                    chk("wr_ovf", {31'h0, ovf}, {31'h0, it.ovf});
                    chk("wr_busy", {31'h0, busy}, 32'd1);
                end
            end
            if (done) begin
                done_cyc.push_back(cyc);
                chk("done_no_write", {31'h0, mem_wr_en}, 32'd0);
                chk("done_after_last", {27'h0, prev_wr, prev_addr}, {27'h0, 1'b1, 4'd8});
                chk("done_busy", {31'h0, busy}, 32'd1);
            end
            prev_wr   = mem_wr_en;
            prev_addr = mem_addr;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic load(input int v[N]);
        for (int k = 0; k < N; k++) results[k*32 +: 32] = v[k];
    endtask

    task automatic push_drain(input int e[N], input int ovf_from);
        for (int k = 0; k < N; k++) begin
            item_t it;
            it.addr = k;
            it.data = e[k];
            it.ovf  = (ovf_from >= 0) && (k >= ovf_from);
            q.push_back(it);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called right after the accepting edge; counts busy cycles and done latency.
    task automatic wait_done(input string name);
        int lat;
        int busy_n;
        lat    = -1;
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done && lat < 0) lat = i;
        end
        chk({name, "_done_latency"}, 32'(lat), 32'(N + 1));
        chk({name, "_busy_cycles"}, 32'(busy_n), 32'(N + 1));
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_wr_en"}, {31'h0, mem_wr_en}, 32'd0);
        chk({name, "_addr"},  {28'h0, mem_addr},  32'd0);
        chk({name, "_data"},  {16'h0, mem_data},  32'd0);
        chk({name, "_busy"},  {31'h0, busy},      32'd0);
        chk({name, "_done"},  {31'h0, done},      32'd0);
        chk({name, "_ovf"},   {31'h0, ovf},       32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int w0;

        for (int k = 0; k < N; k++) begin
            pat_a[k] = k * 100;
            pat_b[k] = k * 1000 - 4000;
            pat_c[k] = k * 11 - 50;
            pat_d[k] = 8000 - k * 2000;
            pat_x[k] = 32'h0000_7777;
            acc_ov[k] = k * 100;
            exp_ov[k] = k * 100;
        end
        acc_ov[4] = 40000;
        acc_ov[5] = -40000;
        exp_ov[4] = SAT ? 32767  : -25536;
        exp_ov[5] = SAT ? -32768 : 25536;

        reset   = 1'b0;
        start   = 1'b0;
        results = '0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic drain of k*100.
        load(pat_a);
        push_drain(pat_a, -1);
        pulse_start();
        wait_done("basic");

        // Out-of-range elements: wrap or saturate.
        load(acc_ov);
        push_drain(exp_ov, SAT ? 4 : -1);
        pulse_start();
        wait_done("ovf");
        chk("ovf_sticky", {31'h0, ovf}, {31'h0, SAT});

        // Start and new results mid-drain are ignored.
        w0 = wr_total;
        load(pat_b);
        push_drain(pat_b, -1);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mem_wr_en && mem_addr == 4'd3) found = 1'b1;
        end
        chk("mid_reach_addr3", {31'h0, found}, 32'd1);
        load(pat_x);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        chk("mid_done_seen", {31'h0, found}, 32'd1);
        repeat (5) @(negedge clk);
        chk("mid_total_writes", 32'(wr_total - w0), 32'd9);

        // Reset mid-drain at address 5.
        load(pat_c);
        push_drain(pat_c, -1);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (mem_wr_en && mem_addr == 4'd5) found = 1'b1;
        end
        chk("rst_reach_addr5", {31'h0, found}, 32'd1);
        #2 reset = 1'b0;
        #1 chk_idle_outputs("rst_async");
        q.delete();
        repeat (3) @(negedge clk);
        chk("rst_hold_no_write", {31'h0, mem_wr_en}, 32'd0);
        reset = 1'b1;
        load(pat_a);
        push_drain(pat_a, -1);
        pulse_start();
        wait_done("after_rst");

        // Start held high: back-to-back drains every N+2 cycles.
        done_cyc.delete();
        load(pat_d);
        push_drain(pat_d, -1);
        push_drain(pat_d, -1);
        @(negedge clk);
        start = 1'b1;
        repeat (N + 3) @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(negedge clk);
        chk("held_done_count", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() == 2) begin
            chk("held_period", 32'(done_cyc[1] - done_cyc[0]), 32'(N + 2));
        end

        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
